// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification, LSB-first
// sampling at bit centres, stop-bit check with valid / framing_err single-cycle pulses.
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          framing_err_q, framing_err_d;
    logic          busy_q, busy_d;

    // Next-state and output decode; pulses default low so they last a single cycle.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        framing_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = CNT_ZERO;
                if (!rx_s_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (count_q == HALF_LAST) begin
                    count_d = CNT_ZERO;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            DATA: begin
                if (count_q == BIT_LAST) begin
                    count_d            = CNT_ZERO;
                    shreg_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STOP: begin
                if (count_q == BIT_LAST) begin
                    count_d = CNT_ZERO;
                    if (rx_s_q) begin
                        data_out_d = shreg_q;
                        valid_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = BREAK_WAIT;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            BREAK_WAIT: begin
                // A held-low line must return high before a new start can be seen.
                count_d = CNT_ZERO;
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = CNT_ZERO;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Synchroniser, state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= IDLE;
            count_q       <= CNT_ZERO;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'h00;
            data_out_q    <= 8'h00;
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            count_q       <= count_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit: the driver queues the expected
// pulse (kind, data_out, cycle) per frame, and a monitor checks every valid/framing_err.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       framing_err;
    logic       busy;

    uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
        .valid(valid), .framing_err(framing_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_cycles = 0;
    logic [7:0] mdl_last = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cycles++;
        if (valid || framing_err) begin
            check("pulse_exclusive", {31'd0, valid & framing_err}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: valid=%0b framing_err=%0b data_out=%0h", valid, framing_err, data_out);
            end else begin
                e = sbq.pop_front();
                check("pulse_kind_err", {31'd0, framing_err}, {31'd0, e.err});
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 10-cycle bit; callers are always aligned 1 time unit after a posedge.
    task automatic drive_bit(input logic b);
        rx = b;
        wait_cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        exp_t e;
        // 2 synchroniser cycles + HALF_BIT + 9*CLKS_PER_BIT + 1 = 98
        e.at  = cyc + 98;
        e.err = !stop_bit;
        if (stop_bit) mdl_last = d;
        e.data = mdl_last;
        sbq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k = 0;
        while (sbq.size() != 0 && k < limit) begin
            wait_cyc(1);
            k++;
        end
        check(name, sbq.size(), 32'd0);
        sbq.delete();
    endtask

    initial begin
        int b0;
        logic [7:0] ab = 8'h7E;
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(4);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        wait_cyc(200);
        check("idle_data_out", {24'd0, data_out}, 32'h00);
        check("idle_busy_cycles", busy_cycles, 32'd0);

        send_byte(8'hA5, 1'b1);
        wait_drain("drain_a5", 200);
        check("a5_data_out", {24'd0, data_out}, 32'hA5);
        check("a5_busy_low", {31'd0, busy}, 32'd0);

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        wait_drain("drain_b2b", 200);
        check("b2b_last", {24'd0, data_out}, 32'h55);

        b0 = busy_cycles;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(20);
        check("glitch_busy_pulsed", {31'd0, busy_cycles > b0}, 32'd1);
        check("glitch_back_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h3C, 1'b1);
        wait_drain("drain_3c", 200);
        check("3c_data_out", {24'd0, data_out}, 32'h3C);

        send_byte(8'h81, 1'b0);
        wait_cyc(40);
        check("break_busy_high", {31'd0, busy}, 32'd1);
        wait_drain("drain_ferr", 50);
        rx = 1'b1;
        wait_cyc(5);
        check("break_busy_released", {31'd0, busy}, 32'd0);
        wait_cyc(150);
        check("break_keeps_data", {24'd0, data_out}, 32'h3C);

        rx = 1'b0;
        wait_cyc(10);
        for (int i = 0; i < 4; i++) drive_bit(ab[i]);
        rx = ab[4];
        wait_cyc(5);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(3);
        mdl_last = 8'h00;
        check("abort_data_out", {24'd0, data_out}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_cyc(20);
        send_byte(8'h12, 1'b1);
        wait_drain("drain_12", 200);
        check("12_data_out", {24'd0, data_out}, 32'h12);
        wait_cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
